// File: rtl/multdiv_pkg.sv
// Shared types and sizing for the iterative multiply/divide unit.
// MULTDIV_BOOTH4_EN selects the radix-4 Booth multiply loop (16 iterations).
package multdiv_pkg;

    localparam int WIDTH     = 32;
    localparam int CNT_W     = 6;
    localparam int REM_W     = WIDTH + 2;
`ifdef MULTDIV_BOOTH4_EN
    localparam int MUL_ITERS = 16;
`else
    localparam int MUL_ITERS = 32;
`endif
    localparam int DIV_ITERS = 32;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        MUL  = 2'd1,
        DIV  = 2'd2,
        DONE = 2'd3
    } state_t;

    function automatic logic [WIDTH-1:0] mag(input logic [WIDTH-1:0] v);
        return v[WIDTH-1] ? (~v + 1'b1) : v;
    endfunction

endpackage

// File: rtl/multdiv_iter_div_step.sv
// One non-restoring division step on magnitudes; instantiated once and iterated.
module div_step
    import multdiv_pkg::*;
(
    input  logic [REM_W-1:0] rem,
    input  logic [WIDTH-1:0] divisor,
    input  logic             dividend_bit,
    output logic [REM_W-1:0] rem_next,
    output logic             q_bit
);

    logic [REM_W-1:0] shifted;
    logic [REM_W-1:0] dext;

    always_comb begin
        shifted  = {rem[REM_W-2:0], dividend_bit};
        dext     = {2'b00, divisor};
        // negative partial remainder restores by adding instead of subtracting
        rem_next = rem[REM_W-1] ? (shifted + dext) : (shifted - dext);
        q_bit    = ~rem_next[REM_W-1];
    end

endmodule

// File: rtl/multdiv_iter.sv
// Iterative 32-bit signed multiply/divide with one-cycle ready strobe.
// MULTDIV_BOOTH4_EN: radix-4 Booth multiply on signed operands instead of radix-2 on magnitudes.
//
// state | meaning
// IDLE  | waiting for ctrl_MULT / ctrl_DIV (MULT wins)
// MUL   | multiply iterations, then result/exception capture
// DIV   | divide iterations (or immediate divide-by-zero), then capture
// DONE  | data_resultRDY high for this one cycle
module multdiv_iter
    import multdiv_pkg::*;
(
    input  logic             clk,
    input  logic             clr_n,
    input  logic [WIDTH-1:0] operandA,
    input  logic [WIDTH-1:0] operandB,
    input  logic             ctrl_MULT,
    input  logic             ctrl_DIV,
    output logic [WIDTH-1:0] data_result,
    output logic             data_exception,
    output logic             data_resultRDY,
    output logic             busy
);

    localparam logic [CNT_W-1:0] MUL_LAST = CNT_W'(MUL_ITERS);
    localparam logic [CNT_W-1:0] DIV_LAST = CNT_W'(DIV_ITERS);

    state_t             state, state_nx;
    logic [CNT_W-1:0]   cnt;
    logic [WIDTH-1:0]   opnd;
    logic [REM_W-1:0]   acc_hi;
    logic [WIDTH-1:0]   acc_lo;
    logic               neg;

    logic [REM_W-1:0]   rem_next;
    logic               q_bit;
    logic [2*WIDTH-1:0] prod_fin;
    logic               mul_ovf;
    logic [WIDTH-1:0]   quot_fin;
    logic               quot_ovf;
    logic               div_zero;

`ifdef MULTDIV_BOOTH4_EN
    logic               q_1;
    logic [REM_W-1:0]   a_ext;
    logic [REM_W-1:0]   addend;
    logic [REM_W-1:0]   booth_sum;
`else
    logic [WIDTH:0]     mul_sum;
`endif

    div_step u_div_step (
        .rem          (acc_hi),
        .divisor      (opnd),
        .dividend_bit (acc_lo[WIDTH-1]),
        .rem_next     (rem_next),
        .q_bit        (q_bit)
    );

    always_comb begin
`ifdef MULTDIV_BOOTH4_EN
        a_ext = {{2{opnd[WIDTH-1]}}, opnd};
        case ({acc_lo[1:0], q_1})
            3'b001, 3'b010: addend = a_ext;
            3'b011:         addend = a_ext << 1;
            3'b100:         addend = -(a_ext << 1);
            3'b101, 3'b110: addend = -a_ext;
            default:        addend = '0;
        endcase
        booth_sum = acc_hi + addend;
        prod_fin  = {acc_hi[WIDTH-1:0], acc_lo};
`else
        mul_sum  = {1'b0, acc_hi[WIDTH-1:0]} + (acc_lo[0] ? {1'b0, opnd} : '0);
        prod_fin = neg ? -{acc_hi[WIDTH-1:0], acc_lo} : {acc_hi[WIDTH-1:0], acc_lo};
`endif
        mul_ovf  = ~((&prod_fin[2*WIDTH-1:WIDTH-1]) | ~(|prod_fin[2*WIDTH-1:WIDTH-1]));
        quot_fin = neg ? -acc_lo : acc_lo;
        // only a positive 2^31 quotient (MIN / -1) cannot be represented
        quot_ovf = ~neg & acc_lo[WIDTH-1];
        div_zero = (opnd == '0);
    end

    always_ff @(posedge clk or negedge clr_n) begin
        if (!clr_n) state <= IDLE;
        else        state <= state_nx;
    end

    always_comb begin
        state_nx = state;
        case (state)
            IDLE: begin
                if (ctrl_MULT)     state_nx = MUL;
                else if (ctrl_DIV) state_nx = DIV;
            end
            MUL:  if (cnt == MUL_LAST) state_nx = DONE;
            DIV:  if ((cnt == '0 && div_zero) || cnt == DIV_LAST) state_nx = DONE;
            DONE: state_nx = IDLE;
            default: state_nx = IDLE;
        endcase
    end

    always_comb begin
        busy           = (state != IDLE);
        data_resultRDY = (state == DONE);
    end

    always_ff @(posedge clk or negedge clr_n) begin
        if (!clr_n) begin
            cnt            <= '0;
            opnd           <= '0;
            acc_hi         <= '0;
            acc_lo         <= '0;
            neg            <= 1'b0;
            data_result    <= '0;
            data_exception <= 1'b0;
`ifdef MULTDIV_BOOTH4_EN
            q_1            <= 1'b0;
`endif
        end else begin
            case (state)
                IDLE: begin
                    cnt <= '0;
                    if (ctrl_MULT) begin
`ifdef MULTDIV_BOOTH4_EN
                        opnd   <= operandA;
                        acc_lo <= operandB;
                        q_1    <= 1'b0;
`else
                        opnd   <= mag(operandA);
                        acc_lo <= mag(operandB);
`endif
                        acc_hi <= '0;
                        neg    <= operandA[WIDTH-1] ^ operandB[WIDTH-1];
                    end else if (ctrl_DIV) begin
                        opnd   <= mag(operandB);
                        acc_lo <= mag(operandA);
                        acc_hi <= '0;
                        neg    <= operandA[WIDTH-1] ^ operandB[WIDTH-1];
                    end
                end
                MUL: begin
                    if (cnt == MUL_LAST) begin
                        data_result    <= prod_fin[WIDTH-1:0];
                        data_exception <= mul_ovf;
                    end else begin
`ifdef MULTDIV_BOOTH4_EN
                        acc_hi <= {{2{booth_sum[REM_W-1]}}, booth_sum[REM_W-1:2]};
                        acc_lo <= {booth_sum[1:0], acc_lo[WIDTH-1:2]};
                        q_1    <= acc_lo[1];
`else
                        acc_hi <= {2'b00, mul_sum[WIDTH:1]};
                        acc_lo <= {mul_sum[0], acc_lo[WIDTH-1:1]};
`endif
                        cnt    <= cnt + 1'b1;
                    end
                end
                DIV: begin
                    if (cnt == '0 && div_zero) begin
                        data_result    <= '0;
                        data_exception <= 1'b1;
                    end else if (cnt == DIV_LAST) begin
                        data_result    <= quot_fin;
                        data_exception <= quot_ovf;
                    end else begin
                        acc_hi <= rem_next;
                        acc_lo <= {acc_lo[WIDTH-2:0], q_bit};
                        cnt    <= cnt + 1'b1;
                    end
                end
                DONE: cnt <= '0;
                default: cnt <= '0;
            endcase
        end
    end

endmodule

// File: doc/multdiv_iter.md
# multdiv_iter

Iterative 32-bit signed multiply/divide unit in the execute stage of the MIPS datapath. Accepts a one-cycle start pulse from the decode/control logic, runs a multi-cycle shift-add (multiply) or non-restoring (divide) loop, then presents a 32-bit result, an exception flag and a one-cycle ready strobe. The pipeline stall controller and the X/M latch write-enables consume these outputs directly.

## Interface
- WIDTH, 32, operand/result width; only 32 is supported.
- clk  in  1  rising-edge clock.
- clr_n  in  1  asynchronous active-low reset.
- operandA  in  32  multiplicand / dividend, two's complement.
- operandB  in  32  multiplier / divisor, two's complement.
- ctrl_MULT  in  1  start-multiply pulse; sampled on rising clk.
- ctrl_DIV  in  1  start-divide pulse; sampled on rising clk.
- data_result  out  32  low 32 bits of product, or quotient.
- data_exception  out  1  overflow or divide-by-zero for the current result.
- data_resultRDY  out  1  one-cycle strobe: result valid this cycle.
- busy  out  1  high from start edge until the DONE cycle ends.

## Operation
- States: IDLE, MUL, DIV, DONE.
- IDLE: a start edge with ctrl_MULT=1 latches both operands and enters MUL. With ctrl_DIV=1 it latches both operands and enters DIV. If both are 1, MULT wins and DIV is dropped.
- Start pulses in MUL, DIV or DONE are ignored. There is no queueing.
- MUL: radix-2 shift-add on magnitudes in a 64-bit product register. Iteration counter runs 0..31. The sign is applied at the end. Enters DONE after the last iteration.
- MUL overflow: data_exception=1 when product bits [63:31] are not all equal.
- DIV: non-restoring division on magnitudes, 32 iterations. The quotient is truncated toward zero, with sign = signA XOR signB. The remainder is discarded.
- DIV by zero (operandB=0): no iterations. Next state is DONE, data_result=0, data_exception=1.
- DIV 0x80000000 / 0xFFFFFFFF: data_result=0x80000000, data_exception=1.
- DONE: data_resultRDY=1 for exactly one cycle, then IDLE.
- data_result and data_exception are registered. They update only on entry to DONE and hold until the next DONE.
- Reset (async, any state): state=IDLE, counter=0, data_result=0, data_exception=0, data_resultRDY=0, busy=0. An in-flight operation is abandoned and produces no strobe.

## Timing
- Edge E0 samples the start. Iterations run on E1..EN. State becomes DONE at E(N+1), and data_resultRDY is high for the cycle after E(N+1).
- Start-to-RDY latency is N+1 edges: MUL radix-2 N=32 (33 edges); DIV N=32 (33 edges); DIV by zero 1 edge.
- busy is high from after E0 through the DONE cycle. A new start is accepted at the first edge after DONE, i.e. back-to-back with 1 idle-sample gap.

## Configuration
- MULTDIV_BOOTH4_EN defined: MUL uses radix-4 Booth recoding, N=16 iterations, latency 17 edges. Overflow rule and result are identical.
- Undefined: radix-2 shift-add, N=32, as above.
- DIV is unaffected by the macro.

## Structure
- Package multdiv_pkg holds:
  - the state enum (IDLE, MUL, DIV, DONE);
  - WIDTH;
  - MUL_ITERS (32, or 16 under MULTDIV_BOOTH4_EN) and DIV_ITERS=32;
  - the counter width (6 bits).
- One sub-module, div_step: a combinational single non-restoring step. Inputs are partial remainder, divisor and next dividend bit; outputs are the new remainder and the quotient bit. multdiv_iter instantiates it once and iterates it.

## Test plan
- 7 × (−6) via ctrl_MULT: data_resultRDY exactly 33 edges after start (17 with MULTDIV_BOOTH4_EN); data_result=0xFFFFFFD6, exception=0.
- 0x00010000 × 0x00010000: data_result=0x00000000, exception=1. Also 0x80000000 × 1: data_result=0x80000000, exception=0.
- −7 / 2: data_result=0xFFFFFFFD, exception=0, RDY 33 edges after start. Then 5 / 0: RDY 1 edge after start, data_result=0, exception=1.
- 0x80000000 / −1: data_result=0x80000000, exception=1.
- ctrl_MULT and ctrl_DIV both high, operands 3, 4: data_result=12. A second ctrl_DIV pulse mid-operation is ignored, and exactly one RDY strobe occurs.
- Assert clr_n=0 at iteration 10 of a multiply: outputs 0 immediately (asynchronous), no RDY. After release, a fresh 2 × 3 returns 6.
